// File: rtl/aoi_exp_driver_pkg.sv
// Shared types and constants for the AOI expander driver and its term cell.
package aoi_exp_driver_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_e;

   localparam int MAX_TERMS_DEFAULT = 8;
   localparam int CNT_W             = 5;

endpackage

// File: rtl/aoi_exp_driver_exp_term_cell.sv
// One AND-OR pair of the expander: folds the four beat operands into a single term bit.
module exp_term_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   output logic term
);

   assign term = (a & b) | (c & d);

endmodule

// File: rtl/aoi_exp_driver.sv
// Accumulates AND-pair beats into one expander term and holds it as a registered
// X/XBAR pair until the consumer takes it; X/XBAR stay neutral (0/1) otherwise.
module aoi_exp_driver
   import aoi_exp_driver_pkg::*;
#(
   parameter int MAX_TERMS = MAX_TERMS_DEFAULT
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             A,
   input  logic             B,
   input  logic             C,
   input  logic             D,
   input  logic             IN_VALID,
   input  logic             IN_LAST,
   output logic             IN_READY,
   output logic             X,
   output logic             XBAR,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic             OVF,
   output logic [CNT_W-1:0] TERM_CNT
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

   state_e           state_r;
   state_e           state_s;
   logic             beat_s;
   logic             accept_s;
   logic             close_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic [CNT_W-1:0] cnt_inc_s;
   logic             acc_r;
   logic             acc_s;
   logic             acc_fold_s;
   logic             x_r;
   logic             x_s;
   logic             xbar_r;
   logic             xbar_s;
   logic             valid_r;
   logic             valid_s;
   logic             ovf_r;
   logic             ovf_s;
   logic             ready_r;
   logic             ready_s;

   exp_term_cell u_term_cell (
      .a    (A),
      .b    (B),
      .c    (C),
      .d    (D),
      .term (beat_s)
   );

   // Handshake and fold: the first beat of a term loads, later beats OR in.
   always_comb begin
      accept_s = IN_VALID & ready_r;
      if (state_r == IDLE) begin
         cnt_inc_s  = {{(CNT_W-1){1'b0}}, 1'b1};
         acc_fold_s = beat_s;
      end else begin
         cnt_inc_s  = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         acc_fold_s = acc_r | beat_s;
      end
      close_s = accept_s & (IN_LAST | (cnt_inc_s == MAX_CNT));
   end

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE, ACCUM: begin
            if (close_s) begin
               state_s = HOLD;
            end else if (accept_s) begin
               state_s = ACCUM;
            end else begin
               state_s = state_r;
            end
         end
         HOLD: begin
            if (OUT_READY) begin
               state_s = IDLE;
            end else begin
               state_s = HOLD;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Next values of the accumulator, counter and registered outputs.
   always_comb begin
      acc_s   = acc_r;
      cnt_s   = cnt_r;
      x_s     = x_r;
      xbar_s  = xbar_r;
      valid_s = valid_r;
      ovf_s   = ovf_r;
      ready_s = (state_s != HOLD);
      case (state_r)
         IDLE, ACCUM: begin
            if (accept_s) begin
               acc_s = acc_fold_s;
               cnt_s = cnt_inc_s;
            end else begin
               acc_s = acc_r;
               cnt_s = cnt_r;
            end
            if (close_s) begin
               x_s     = acc_fold_s;
               xbar_s  = ~acc_fold_s;
               valid_s = 1'b1;
               ovf_s   = ~IN_LAST;
            end else begin
               x_s     = 1'b0;
               xbar_s  = 1'b1;
               valid_s = 1'b0;
               ovf_s   = 1'b0;
            end
         end
         HOLD: begin
            if (OUT_READY) begin
               acc_s   = 1'b0;
               cnt_s   = {CNT_W{1'b0}};
               x_s     = 1'b0;
               xbar_s  = 1'b1;
               valid_s = 1'b0;
               ovf_s   = 1'b0;
            end else begin
               acc_s   = acc_r;
               cnt_s   = cnt_r;
               x_s     = x_r;
               xbar_s  = xbar_r;
               valid_s = valid_r;
               ovf_s   = ovf_r;
            end
         end
         default: begin
            acc_s   = 1'b0;
            cnt_s   = {CNT_W{1'b0}};
            x_s     = 1'b0;
            xbar_s  = 1'b1;
            valid_s = 1'b0;
            ovf_s   = 1'b0;
         end
      endcase
   end

   // Datapath and output registers; reset leaves the expander neutral.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         acc_r   <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
         x_r     <= 1'b0;
         xbar_r  <= 1'b1;
         valid_r <= 1'b0;
         ovf_r   <= 1'b0;
         ready_r <= 1'b1;
      end else begin
         acc_r   <= acc_s;
         cnt_r   <= cnt_s;
         x_r     <= x_s;
         xbar_r  <= xbar_s;
         valid_r <= valid_s;
         ovf_r   <= ovf_s;
         ready_r <= ready_s;
      end
   end

   assign IN_READY  = ready_r;
   assign X         = x_r;
   assign XBAR      = xbar_r;
   assign OUT_VALID = valid_r;
   assign OVF       = ovf_r;
   assign TERM_CNT  = cnt_r;

endmodule

// File: tb/tb_aoi_exp_driver.sv
// Scoreboard bench for aoi_exp_driver: directed corner cases plus randomized beats.
module tb_aoi_exp_driver;

   localparam int MAXT = 8;

   logic       CLK       = 1'b0;
   logic       RST_N     = 1'b0;
   logic       A         = 1'b0;
   logic       B         = 1'b0;
   logic       C         = 1'b0;
   logic       D         = 1'b0;
   logic       IN_VALID  = 1'b0;
   logic       IN_LAST   = 1'b0;
   logic       OUT_READY = 1'b0;
   logic       IN_READY;
   logic       X;
   logic       XBAR;
   logic       OUT_VALID;
   logic       OVF;
   logic [4:0] TERM_CNT;

   typedef struct {
      logic x;
      int   cnt;
      logic ovf;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   total = 0;
   int   bad   = 0;
   int   m_cnt = 0;
   logic m_acc = 1'b0;
   bit   bp_mode     = 1'b0;
   logic ready_force = 1'b1;
   bit   mon_en      = 1'b0;
   logic prev_valid  = 1'b0;

   aoi_exp_driver #(.MAX_TERMS(MAXT)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .A         (A),
      .B         (B),
      .C         (C),
      .D         (D),
      .IN_VALID  (IN_VALID),
      .IN_LAST   (IN_LAST),
      .IN_READY  (IN_READY),
      .X         (X),
      .XBAR      (XBAR),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OVF       (OVF),
      .TERM_CNT  (TERM_CNT)
   );

   always #5 CLK = ~CLK;

   function automatic logic aoi_y(input logic a, input logic b, input logic c,
                                  input logic d, input logic x);
      return ~((a & b) | (c & d) | x);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, expv, $time);
      end
   endtask

   // Offer one beat until accepted, then fold it into the reference term.
   task automatic send_beat(input logic a, input logic b, input logic c,
                            input logic d, input logic last);
      bit   done = 1'b0;
      exp_t e;
      @(negedge CLK);
      A = a; B = b; C = c; D = d; IN_LAST = last; IN_VALID = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         if (IN_READY) begin
            @(posedge CLK);
            done = 1'b1;
         end else begin
            @(negedge CLK);
         end
      end
      if (!done) begin
         chk("accept_timeout", 32'd0, 32'd1);
      end else begin
         m_acc = m_acc | ((a & b) | (c & d));
         m_cnt++;
         if (last || m_cnt == MAXT) begin
            e.x = m_acc; e.cnt = m_cnt; e.ovf = !last;
            exp_q.push_back(e);
            m_acc = 1'b0;
            m_cnt = 0;
         end
      end
      #1 IN_VALID = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge CLK);
         if (!OUT_VALID) done = 1'b1;
      end
      if (!done) chk("hold_exit_timeout", 32'd0, 32'd1);
   endtask

   // Pulse reset mid-cycle and check the outputs go neutral at once.
   task automatic do_reset();
      @(negedge CLK);
      #2 RST_N = 1'b0;
      #1;
      chk("rst_x", X, 32'd0);
      chk("rst_xbar", XBAR, 32'd1);
      chk("rst_cnt", TERM_CNT, 32'd0);
      chk("rst_valid", OUT_VALID, 32'd0);
      m_acc = 1'b0;
      m_cnt = 0;
      exp_q.delete();
      repeat (2) @(negedge CLK);
      #2 RST_N = 1'b1;
   endtask

   // Consumer side: random back-pressure or a forced level.
   initial begin
      forever begin
         @(negedge CLK);
         #1;
         if (bp_mode) OUT_READY = ($urandom_range(0, 2) != 0);
         else         OUT_READY = ready_force;
      end
   end

   // Monitor: pop the expected term when OUT_VALID rises, check it every held cycle.
   initial begin
      cur.x = 1'b0; cur.cnt = 0; cur.ovf = 1'b0;
      forever begin
         @(negedge CLK);
         if (mon_en) begin
            if (OUT_VALID && !prev_valid) begin
               if (exp_q.size() == 0) chk("unexpected_term", 32'd1, 32'd0);
               else cur = exp_q.pop_front();
            end
            if (OUT_VALID) begin
               chk("held_x", X, 32'(cur.x));
               chk("held_xbar", XBAR, 32'(!cur.x));
               chk("held_cnt", TERM_CNT, cur.cnt);
               chk("held_ovf", OVF, 32'(cur.ovf));
               chk("held_in_ready", IN_READY, 32'd0);
            end else begin
               chk("idle_x", X, 32'd0);
               chk("idle_xbar", XBAR, 32'd1);
               chk("idle_ovf", OVF, 32'd0);
               chk("idle_in_ready", IN_READY, 32'd1);
               chk("aoi_neutral_y", aoi_y(1'b0, 1'b0, 1'b0, 1'b0, X), 32'd1);
            end
            prev_valid = OUT_VALID;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge CLK);
      #2 RST_N = 1'b1;
      @(negedge CLK);
      chk("reset_in_ready", IN_READY, 32'd1);
      chk("reset_x", X, 32'd0);
      chk("reset_xbar", XBAR, 32'd1);
      chk("reset_valid", OUT_VALID, 32'd0);
      chk("reset_ovf", OVF, 32'd0);
      chk("reset_cnt", TERM_CNT, 32'd0);
      mon_en = 1'b1;

      // Single closing beat: term visible one cycle later.
      send_beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("single_valid", OUT_VALID, 32'd1);
      chk("single_x", X, 32'd1);
      chk("single_xbar", XBAR, 32'd0);
      chk("single_cnt", TERM_CNT, 32'd1);
      chk("single_ovf", OVF, 32'd0);
      wait_idle();

      // Three beats with a stalled consumer.
      ready_force = 1'b0;
      send_beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_beat(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      send_beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (4) begin
         @(negedge CLK);
         chk("stall_x", X, 32'd1);
         chk("stall_in_ready", IN_READY, 32'd0);
      end
      ready_force = 1'b1;
      wait_idle();
      chk("stall_x_after", X, 32'd0);
      chk("stall_xbar_after", XBAR, 32'd1);

      // Force-close at MAX_TERMS without IN_LAST.
      ready_force = 1'b0;
      repeat (MAXT) send_beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ovf_valid", OUT_VALID, 32'd1);
      chk("ovf_x", X, 32'd0);
      chk("ovf_xbar", XBAR, 32'd1);
      chk("ovf_flag", OVF, 32'd1);
      chk("ovf_cnt", TERM_CNT, MAXT);
      ready_force = 1'b1;
      wait_idle();

      // Reset mid-accumulation, then a fresh term.
      send_beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      send_beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("partial_cnt", TERM_CNT, 32'd2);
      do_reset();
      send_beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("fresh_cnt", TERM_CNT, 32'd1);
      chk("fresh_x", X, 32'd0);
      wait_idle();

      // Reset mid-hold discards the held term.
      ready_force = 1'b0;
      send_beat(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      do_reset();
      repeat (3) @(negedge CLK);
      chk("hold_reset_valid", OUT_VALID, 32'd0);
      ready_force = 1'b1;

      // IN_VALID held across HOLD exit: no acceptance until IDLE.
      ready_force = 1'b0;
      send_beat(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      fork
         send_beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
         begin
            repeat (3) @(negedge CLK);
            ready_force = 1'b1;
         end
      join
      chk("noby_cnt", TERM_CNT, 32'd1);
      chk("noby_valid", OUT_VALID, 32'd1);
      chk("noby_x", X, 32'd0);
      wait_idle();

      // Randomized beats with random back-pressure.
      bp_mode = 1'b1;
      for (int n = 0; n < 80; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge CLK);
         send_beat(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 4) == 0));
      end
      bp_mode     = 1'b0;
      ready_force = 1'b1;
      for (int i = 0; i < 100 && (exp_q.size() != 0 || OUT_VALID); i++) @(negedge CLK);
      @(negedge CLK);
      chk("drain_queue", exp_q.size(), 32'd0);
      mon_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aoi_exp_driver.md
AOI_EXP_DRIVER -- requirements
Module: aoi_exp_driver

Interface
REQ-001 SHALL have parameter MAX_TERMS, default 8, meaning the maximum AND-pair beats folded into one expander term (range 1..16).
REQ-002 SHALL have port CLK input 1 meaning the single rising-edge clock for all state.
REQ-003 SHALL have port RST_N input 1 meaning the asynchronous, active-low reset.
REQ-004 SHALL have ports A, B, C, D input 1 each meaning the AND-pair operands of one beat.
REQ-005 SHALL have port IN_VALID input 1 meaning the beat on A..D is presented.
REQ-006 SHALL have port IN_LAST input 1 meaning the presented beat closes the current term.
REQ-007 SHALL have port IN_READY output 1 meaning the block accepts a beat this cycle.
REQ-008 SHALL have ports X output 1 and XBAR output 1 meaning the expander pair consumed by the AOI expander gates.
REQ-009 SHALL have port OUT_VALID output 1 meaning X/XBAR hold a completed term.
REQ-010 SHALL have port OUT_READY input 1 meaning the consumer has taken the term.
REQ-011 SHALL have port OVF output 1 meaning the current term was force-closed at MAX_TERMS without IN_LAST.
REQ-012 SHALL have port TERM_CNT output 5 meaning the number of beats folded into the current or held term.

Function
REQ-013 SHALL implement states IDLE, ACCUM, HOLD.
REQ-014 A beat SHALL be accepted when IN_VALID and IN_READY are both 1 on a rising CLK edge.
REQ-015 IN_READY SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-016 Each accepted beat SHALL OR (A&B)|(C&D) into the accumulator; the first beat after IDLE SHALL load it instead of OR-ing.
REQ-017 TERM_CNT SHALL become 1 on the first accepted beat and increment by 1 per further accepted beat, never exceeding MAX_TERMS.
REQ-018 IDLE->ACCUM on an accepted beat with IN_LAST=0 and TERM_CNT reaching below MAX_TERMS; IDLE->HOLD on an accepted beat with IN_LAST=1.
REQ-019 ACCUM->HOLD on an accepted beat with IN_LAST=1, or when the accepted beat makes TERM_CNT equal MAX_TERMS.
REQ-020 OVF SHALL be set on entry to HOLD only when the closing beat had IN_LAST=0 and TERM_CNT reached MAX_TERMS; cleared on leaving HOLD.
REQ-021 In HOLD, OUT_VALID SHALL be 1, X SHALL equal the accumulator and XBAR SHALL equal its complement, both registered (one-cycle latency from the closing beat).
REQ-022 HOLD->IDLE on a rising edge with OUT_READY=1; X SHALL return to 0, XBAR to 1, OUT_VALID, OVF and TERM_CNT to 0 in the same edge.
REQ-023 Outside HOLD, X SHALL be 0 and XBAR SHALL be 1 (neutral expander: no contribution to the AOI output).
REQ-024 OUT_READY outside HOLD SHALL be ignored; IN_VALID in HOLD SHALL be ignored (no beat lost silently: IN_READY=0).
REQ-025 No bypass: a beat offered in the cycle HOLD exits SHALL not be accepted until IDLE.
REQ-026 With MAX_TERMS=1, every accepted beat SHALL go IDLE->HOLD, OVF set if IN_LAST=0.

Reset
REQ-027 RST_N low SHALL asynchronously force IDLE, accumulator 0, X=0, XBAR=1, OUT_VALID=0, OVF=0, TERM_CNT=0, IN_READY=1 after release.
REQ-028 Reset asserted mid-ACCUM or mid-HOLD SHALL discard the partial or held term with no output pulse.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, ACCUM, HOLD) and the MAX_TERMS default constant.
REQ-030 One combinational sub-module exp_term_cell SHALL compute (A&B)|(C&D); the FSM, counter and accumulator stay in aoi_exp_driver.

Verification
REQ-031 Single beat A=B=1,C=D=0,IN_LAST=1 -> next cycle OUT_VALID=1, X=1, XBAR=0, TERM_CNT=1, OVF=0.
REQ-032 Three beats (0000,0011,0000) last on third, OUT_READY=0 for 4 cycles -> X=1 held, IN_READY=0 throughout, then OUT_READY=1 -> X=0, XBAR=1.
REQ-033 Eight beats all 0, no IN_LAST, MAX_TERMS=8 -> HOLD with X=0, XBAR=1, OVF=1, TERM_CNT=8.
REQ-034 RST_N pulsed low after two accepted beats (first A=B=1) -> X=0, XBAR=1, TERM_CNT=0 immediately; next term starts fresh.
REQ-035 IN_VALID=1 held continuously across HOLD exit -> no beat accepted while IN_READY=0; first acceptance in IDLE, TERM_CNT=1.
REQ-036 Check X AOI-composed with A..D=0: neutral output (X=0, XBAR=1) yields AOI Y=1 whenever OUT_VALID=0.
